// File: rtl/pad_attr_seq_ctrl.sv
// pad_attr_seq_ctrl: per-pad attribute shadow registers with a round-robin sequencer that applies one pad at a time with a settle gap (PAD_ATTR_SEQ_CTRL_STRICT_EN rejects writes carrying illegal bits)
module pad_attr_seq_ctrl #(
  parameter int                 NPads        = 4,
  parameter int                 AttrW        = 8,
  parameter logic [3*NPads-1:0] PadTypeVec   = {NPads{3'h1}},
  parameter logic [AttrW-1:0]   AttrMaskA    = AttrW'(8'h03),
  parameter logic [AttrW-1:0]   AttrMaskB    = AttrW'(8'hFF),
  parameter int                 SettleCycles = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [4:0]             wr_idx_i,
  input  logic [AttrW-1:0]       wr_attr_i,
  input  logic [4:0]             rd_idx_i,
  output logic [AttrW-1:0]       rd_attr_o,
  output logic [NPads*AttrW-1:0] attr_o,
  output logic                   apply_o,
  output logic [4:0]             apply_idx_o,
  output logic                   busy_o,
  output logic                   err_o
);
  typedef enum logic [1:0] {IDLE, APPLY, SETTLE} state_e;
  state_e                 state_q, state_d;
  logic [4:0]             sel_q, sel_d, rr_q, rr_d, pick, pick_hi, apply_idx_q, apply_idx_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [AttrW-1:0]       shadow_q [NPads];
  logic [AttrW-1:0]       shadow_d [NPads];
  logic [AttrW-1:0]       mask [NPads];
  logic [AttrW-1:0]       wr_mask;
  logic [NPads-1:0]       pending_q, pending_d;
  logic [NPads*AttrW-1:0] attr_q, attr_d;
  logic                   apply_q, apply_d, busy_q, busy_d, err_q, err_d;
  logic                   wr_fire, wr_in, wr_bad, wr_ok, any_hi;
  always_comb begin
    for (int k = 0; k < NPads; k++)
      mask[k] = PadTypeVec[3*k +: 3] == 3'h0 ? AttrMaskA :
                PadTypeVec[3*k +: 3] == 3'h1 ? AttrMaskB : '0;
  end
  always_comb begin
    wr_mask   = '0;
    rd_attr_o = '0;
    for (int k = 0; k < NPads; k++) begin
      if (wr_idx_i == 5'(k)) wr_mask = mask[k];
      if (rd_idx_i == 5'(k)) rd_attr_o = shadow_q[k];
    end
  end
  assign wr_ready_o = state_q != APPLY;
  assign wr_fire    = wr_valid_i & wr_ready_o;
  assign wr_in      = 32'(wr_idx_i) < NPads;
`ifdef PAD_ATTR_SEQ_CTRL_STRICT_EN
  assign wr_bad     = |(wr_attr_i & ~wr_mask);
`else
  assign wr_bad     = 1'b0;
`endif
  assign wr_ok      = wr_fire & wr_in & ~wr_bad;
  // Lowest pending pad above rr wins; otherwise wrap to the lowest pending pad overall.
  always_comb begin
    pick    = '0;
    pick_hi = '0;
    any_hi  = 1'b0;
    for (int k = NPads - 1; k >= 0; k--) begin
      if (pending_q[k]) begin
        pick = 5'(k);
        if (k > int'(rr_q)) begin
          pick_hi = 5'(k);
          any_hi  = 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      rr_q        <= 5'(NPads - 1);
      cnt_q       <= '0;
      pending_q   <= '0;
      attr_q      <= '0;
      apply_q     <= 1'b0;
      apply_idx_q <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      for (int k = 0; k < NPads; k++) shadow_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      attr_q      <= attr_d;
      apply_q     <= apply_d;
      apply_idx_q <= apply_idx_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      shadow_q    <= shadow_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? (|pending_q ? APPLY : IDLE) :
              state_q == APPLY ? (SettleCycles > 0 ? SETTLE : IDLE) :
              cnt_q == 8'(SettleCycles - 1) ? IDLE : SETTLE;
    sel_d   = state_q == IDLE ? (any_hi ? pick_hi : pick) : sel_q;
    cnt_d   = state_q == SETTLE ? cnt_q + 8'd1 : '0;
  end
  // The write port is closed in APPLY, so the apply clear and a write set never collide.
  always_comb begin
    shadow_d    = shadow_q;
    pending_d   = pending_q;
    attr_d      = attr_q;
    rr_d        = state_q == APPLY ? sel_q : rr_q;
    apply_d     = state_q == APPLY;
    apply_idx_d = state_q == APPLY ? sel_q : '0;
    err_d       = wr_fire & ~wr_ok;
    for (int k = 0; k < NPads; k++) begin
      if (state_q == APPLY && sel_q == 5'(k)) begin
        attr_d[k*AttrW +: AttrW] = shadow_q[k];
        pending_d[k]             = 1'b0;
      end
      if (wr_ok && wr_idx_i == 5'(k)) begin
        shadow_d[k]  = wr_attr_i & wr_mask;
        pending_d[k] = 1'b1;
      end
    end
    busy_d = (state_d != IDLE) | (|pending_d);
  end
  assign attr_o      = attr_q;
  assign apply_o     = apply_q;
  assign apply_idx_o = apply_idx_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;
endmodule
